// File: rtl/conv_axis_pkg.sv
// Shared types and defaults for the convolution accelerator's AXI-Stream FIFOs.
// The entry struct is the {tlast, tdata} word carried through the stream path.
package conv_axis_pkg;
  localparam int OUTW_DEF  = 24;
  localparam int DEPTH_DEF = 19;

  typedef struct packed {
    logic                tlast;
    logic [OUTW_DEF-1:0] tdata;
  } conv_entry_t;
endpackage

// File: rtl/fifo_ram_dp.sv
// Dual-port storage: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset.
module fifo_ram_dp #(
  parameter int W     = 25,
  parameter int DEPTH = 19,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axis_fifo_out_v2.sv
// First-word-fall-through output FIFO between the conv datapath and the
// AXI-Stream sink; any depth >= 2, registered ready/valid/almost_full.
module axis_fifo_out_v2
  import conv_axis_pkg::*;
#(
  parameter int OUTW         = OUTW_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int CNTW        = $clog2(DEPTH + 1),
  localparam int PTRW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [OUTW-1:0] IN_AXIS_TDATA,
  input  logic            IN_AXIS_TLAST,
  input  logic            IN_AXIS_TVALID,
  output logic            IN_AXIS_TREADY,
  output logic [OUTW-1:0] OUT_AXIS_TDATA,
  output logic            OUT_AXIS_TLAST,
  output logic            OUT_AXIS_TVALID,
  input  logic            OUT_AXIS_TREADY,
  output logic [CNTW-1:0] count,
  output logic            almost_full
);
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [CNTW-1:0] w_count_nxt;
  logic            r_in_rdy;
  logic            r_out_vld;
  logic            r_afull;
  logic            w_push;
  logic            w_pop;
  logic [OUTW:0]   w_rd_entry;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign w_push = IN_AXIS_TVALID & r_in_rdy;
  assign w_pop  = r_out_vld & OUT_AXIS_TREADY;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNTW'(1);
        2'b01:   w_count_nxt = r_count - CNTW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_afull   <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count   <= w_count_nxt;
      r_in_rdy  <= (w_count_nxt < CNTW'(DEPTH));
      r_out_vld <= (w_count_nxt != '0);
      r_afull   <= (w_count_nxt >= CNTW'(AFULL_THRESH));
    end
  end

  // A push in a flush cycle is dropped, so the write is masked too.
  fifo_ram_dp #(
    .W     (OUTW + 1),
    .DEPTH (DEPTH),
    .AW    (PTRW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push & ~flush),
    .i_waddr (r_wr_ptr),
    .i_wdata ({IN_AXIS_TLAST, IN_AXIS_TDATA}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  assign IN_AXIS_TREADY  = r_in_rdy;
  assign OUT_AXIS_TVALID = r_out_vld;
  assign OUT_AXIS_TDATA  = r_out_vld ? w_rd_entry[OUTW-1:0] : '0;
  assign OUT_AXIS_TLAST  = r_out_vld & w_rd_entry[OUTW];
  assign count           = r_count;
  assign almost_full     = r_afull;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= CNTW'(DEPTH));
      assert (!(w_pop && r_count == '0));
      assert (!(w_push && r_count == CNTW'(DEPTH)));
    end
  end
`endif
endmodule

// File: tb/tb_axis_fifo_out_v2.sv
// Directed and random checks of axis_fifo_out_v2 against a queue model.
// Fill phase is table-driven with hand-derived expectations.
module tb_axis_fifo_out_v2;
  import conv_axis_pkg::*;

  localparam int DEPTH = 19;
  localparam int AF    = 17;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [23:0] in_d;
  logic        in_l;
  logic        in_v;
  logic        in_r;
  logic [23:0] out_d;
  logic        out_l;
  logic        out_v;
  logic        out_r;
  logic [4:0]  count;
  logic        afull;

  axis_fifo_out_v2 dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .IN_AXIS_TDATA   (in_d),
    .IN_AXIS_TLAST   (in_l),
    .IN_AXIS_TVALID  (in_v),
    .IN_AXIS_TREADY  (in_r),
    .OUT_AXIS_TDATA  (out_d),
    .OUT_AXIS_TLAST  (out_l),
    .OUT_AXIS_TVALID (out_v),
    .OUT_AXIS_TREADY (out_r),
    .count           (count),
    .almost_full     (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  conv_entry_t q[$];
  logic        m_irdy = 1'b0;
  logic        last_push;
  int          m_pops = 0;
  int          wid = 0;
  logic        seen_bad = 1'b0;

  always @(negedge clk)
    if (out_v && out_d == 24'hABCDEF) seen_bad = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic l,
                      input logic r, input logic f);
    logic p;
    logic po;
    in_v  = v;
    in_d  = d;
    in_l  = l;
    out_r = r;
    flush = f;
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_r), 32'(m_irdy));
    chk("out_valid", 32'(out_v), 32'(q.size() != 0));
    chk("almost_full", 32'(afull), 32'(q.size() >= AF));
    chk("out_data", 32'(out_d), q.size() != 0 ? 32'(q[0].tdata) : 32'd0);
    chk("out_last", 32'(out_l), q.size() != 0 ? 32'(q[0].tlast) : 32'd0);
    p  = v & m_irdy;
    po = (q.size() != 0) & r;
    tick();
    if (f) begin
      q.delete();
    end else begin
      if (po) begin
        void'(q.pop_front());
        m_pops++;
      end
      if (p) q.push_back('{tlast: l, tdata: d});
    end
    m_irdy    = (q.size() < DEPTH);
    last_push = p & ~f;
  endtask

  task automatic push_word(input logic r);
    step(1'b1, 24'h010000 + 24'(wid), (wid % 8) == 7, r, 1'b0);
    if (last_push) wid++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++)
      step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic        vin;
    logic [23:0] din;
    logic        lin;
    logic [4:0]  e_cnt;
    logic        e_irdy;
    logic        e_ovld;
    logic        e_af;
    logic [23:0] e_dat;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic        hold;
    logic [23:0] hold_d;
    int          sent;

    for (int i = 0; i < 20; i++) begin
      tbl[i].vin    = 1'b1;
      tbl[i].din    = 24'(i + 1);
      tbl[i].lin    = ((i + 1) % 8) == 0;
      tbl[i].e_cnt  = (i < 19) ? 5'(i) : 5'd19;
      tbl[i].e_irdy = (i < 19);
      tbl[i].e_ovld = (i != 0);
      tbl[i].e_af   = (i >= 17);
      tbl[i].e_dat  = (i != 0) ? 24'h000001 : 24'h0;
    end

    reset = 1'b1;
    flush = 1'b0;
    in_v  = 1'b0;
    in_d  = '0;
    in_l  = 1'b0;
    out_r = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", 32'(out_v), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ready", 32'(in_r), 0);
      tick();
    end
    reset = 1'b0;
    #1;
    chk("rel_ready_pre", 32'(in_r), 0);
    tick();
    chk("rel_ready_post", 32'(in_r), 1);
    chk("rel_count", 32'(count), 0);
    chk("rel_data", 32'(out_d), 0);
    m_irdy = 1'b1;

    for (int i = 0; i < 20; i++) begin
      in_v  = tbl[i].vin;
      in_d  = tbl[i].din;
      in_l  = tbl[i].lin;
      out_r = 1'b0;
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_ready", 32'(in_r), 32'(tbl[i].e_irdy));
      chk("tbl_valid", 32'(out_v), 32'(tbl[i].e_ovld));
      chk("tbl_afull", 32'(afull), 32'(tbl[i].e_af));
      chk("tbl_data", 32'(out_d), 32'(tbl[i].e_dat));
      tick();
    end
    chk("full_count", 32'(count), 19);
    chk("full_ready", 32'(in_r), 0);
    for (int i = 0; i < 19; i++)
      q.push_back('{tlast: ((i + 1) % 8) == 0, tdata: 24'(i + 1)});
    m_irdy = 1'b0;

    step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    chk("full_pop_ready", 32'(in_r), 1);
    drain();

    for (int k = 0; k < 40; k++) push_word(1'b1);
    drain();

    for (int k = 0; k < 10; k++) push_word(1'b0);
    for (int k = 0; k < 50; k++) begin
      push_word(1'b1);
      chk("simul_count", 32'(count), 10);
    end

    while (q.size() < DEPTH) push_word(1'b0);
    push_word(1'b1);
    chk("full_pop_ready2", 32'(in_r), 1);
    drain();
    push_word(1'b1);
    chk("empty_push_valid", 32'(out_v), 1);
    drain();

    for (int k = 0; k < 7; k++) push_word(1'b0);
    step(1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_v), 0);
    chk("flush_ready", 32'(in_r), 1);
    for (int k = 0; k < 3; k++) push_word(1'b0);
    drain();

    for (int k = 0; k < 5; k++) push_word(1'b0);
    in_v = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(out_v), 0);
    chk("async_rst_ready", 32'(in_r), 0);
    chk("async_rst_data", 32'(out_d), 0);
    tick();
    tick();
    reset = 1'b0;
    q.delete();
    m_irdy = 1'b0;
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

    m_pops = 0;
    sent   = 0;
    hold   = 1'b0;
    hold_d = '0;
    for (int c = 0; c < 20000 && m_pops < 1000; c++) begin
      logic v;
      logic r;
      v = (sent < 1000) && ($urandom_range(1) == 1);
      r = ($urandom_range(1) == 1);
      if (hold) chk("stable_data", 32'(out_d), 32'(hold_d));
      hold   = out_v && !r;
      hold_d = out_d;
      step(v, 24'h300000 + 24'(sent), (sent % 8) == 7, r, 1'b0);
      if (last_push) sent++;
    end
    chk("rand_pops", 32'(m_pops), 1000);
    chk("flush_word_absent", 32'(seen_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
